// File: rtl/reg_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// reg_ctrl_pkg : shared opcode/state encodings and sizes for reg_xfer_ctrl
// Rev 1.0
// ============================================================================
package reg_ctrl_pkg;

  localparam int NREG = 8;
  localparam int SELW = 3;
  localparam int DW   = 16;
  localparam int FNW  = 4;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ALU = 2'b01,
    OP_LDI = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [SELW-1:0] src_a;
    logic [SELW-1:0] src_b;
    logic [SELW-1:0] dst;
    logic [DW-1:0]   imm;
    logic [FNW-1:0]  fn;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/reg_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// reg_xfer_ctrl_if : command, register-bus and ALU signals of reg_xfer_ctrl
// Rev 1.0
// ============================================================================
interface reg_xfer_ctrl_if;
  import reg_ctrl_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [SELW-1:0] src_a;
  logic [SELW-1:0] src_b;
  logic [SELW-1:0] dst;
  logic [DW-1:0]   imm;
  logic [FNW-1:0]  fn;
  logic [DW-1:0]   A_bus;
  logic [DW-1:0]   alu_y;
  logic [NREG-1:0] RA;
  logic [NREG-1:0] RB;
  logic [FNW-1:0]  alu_fn;
  logic [DW-1:0]   S_bus;
  logic [NREG-1:0] SR;
  logic            busy;
  logic            done;

  // Master is the command source plus the register bank / ALU environment.
  modport master (
    output start, op, src_a, src_b, dst, imm, fn, A_bus, alu_y,
    input  RA, RB, alu_fn, S_bus, SR, busy, done
  );

  modport slave (
    input  start, op, src_a, src_b, dst, imm, fn, A_bus, alu_y,
    output RA, RB, alu_fn, S_bus, SR, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/reg_xfer_ctrl_onehot_decoder.sv
`default_nettype none
// ============================================================================
// onehot_decoder : binary index to one-hot select, all-zero when disabled
// Rev 1.0
// ============================================================================
module onehot_decoder #(
  parameter int SELW = 3,
  parameter int NREG = 8
) (
  input  wire logic            en_i,
  input  wire logic [SELW-1:0] idx_i,
  output logic      [NREG-1:0] onehot_o
);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == SELW'(gi));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// reg_xfer_ctrl : IDLE/READ/WRITE sequencer for register-bank transfers
// Rev 1.0
// ============================================================================
module reg_xfer_ctrl
  import reg_ctrl_pkg::*;
(
  input wire logic        CLK,
  input wire logic        CLR,
  reg_xfer_ctrl_if.slave  bus
);

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [DW-1:0] t_q, t_d;
  logic          done_q, done_d;
  logic          ra_en, rb_en, sr_en;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    t_d     = t_q;
    done_d  = 1'b0;
    ra_en   = 1'b0;
    rb_en   = 1'b0;
    sr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cmd_d.op    = op_e'(bus.op);
          cmd_d.src_a = bus.src_a;
          cmd_d.src_b = bus.src_b;
          cmd_d.dst   = bus.dst;
          cmd_d.imm   = bus.imm;
          cmd_d.fn    = bus.fn;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        ra_en = (cmd_q.op == OP_MOV) || (cmd_q.op == OP_ALU);
        rb_en = (cmd_q.op == OP_ALU);
        // T captures the source operand so WRITE may target a source register.
        case (cmd_q.op)
          OP_MOV:  t_d = bus.A_bus;
          OP_ALU:  t_d = bus.alu_y;
          OP_LDI:  t_d = cmd_q.imm;
          default: t_d = '0;
        endcase
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        sr_en   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  onehot_decoder #(.SELW(SELW), .NREG(NREG)) u_dec_ra (
    .en_i     (ra_en),
    .idx_i    (cmd_q.src_a),
    .onehot_o (bus.RA)
  );

  onehot_decoder #(.SELW(SELW), .NREG(NREG)) u_dec_rb (
    .en_i     (rb_en),
    .idx_i    (cmd_q.src_b),
    .onehot_o (bus.RB)
  );

  onehot_decoder #(.SELW(SELW), .NREG(NREG)) u_dec_sr (
    .en_i     (sr_en),
    .idx_i    (cmd_q.dst),
    .onehot_o (bus.SR)
  );

  // The latched fn only changes on command acceptance, so it holds between commands.
  assign bus.alu_fn = cmd_q.fn;
  assign bus.S_bus  = t_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_reg_xfer_ctrl : directed and randomized checks of reg_xfer_ctrl
// Rev 1.0
// ============================================================================
module tb_reg_xfer_ctrl;
  import reg_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic CLR;
  reg_xfer_ctrl_if bus();

  reg_xfer_ctrl dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] gpr   [NREG];
  logic [DW-1:0] model [NREG];
  logic          force_alu;
  logic [DW-1:0] forced_y;
  logic [DW-1:0] a_v, b_v;

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [FNW-1:0] f);
    logic [DW-1:0] r;
    case (f[1:0])
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a ^ b;
      default: r = a & b;
    endcase
    return r ^ {f, {(DW-FNW){1'b0}}};
  endfunction

  // Register bank and ALU environment seen by the controller.
  always_comb begin
    a_v = '0;
    b_v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.RA[i]) a_v = a_v | gpr[i];
      if (bus.RB[i]) b_v = b_v | gpr[i];
    end
    bus.A_bus = a_v;
    bus.alu_y = force_alu ? forced_y : alu_f(a_v, b_v, bus.alu_fn);
  end

  task automatic cyc();
    logic [NREG-1:0] sr = bus.SR;
    logic [DW-1:0]   s  = bus.S_bus;
    n_cmp++;
    if (!$onehot0(bus.RA) || !$onehot0(bus.RB) || !$onehot0(sr)) begin
      n_bad++;
      $display("FAIL onehot0: RA=%b RB=%b SR=%b required at most one bit each", bus.RA, bus.RB, sr);
    end
    n_cmp++;
    if (sr != '0 && !bus.busy) begin
      n_bad++;
      $display("FAIL sr_idle: SR=%b while busy=0, required SR=0", sr);
    end
    @(posedge CLK);
    for (int i = 0; i < NREG; i++) if (sr[i]) gpr[i] = s;
    @(negedge CLK);
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [SELW-1:0] a, input logic [SELW-1:0] b,
                           input logic [SELW-1:0] d, input logic [DW-1:0] imm, input logic [FNW-1:0] fn);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.dst   = d;
    bus.imm   = imm;
    bus.fn    = fn;
  endtask

  task automatic noise(input logic st);
    bus.start = st;
    bus.op    = 2'($urandom);
    bus.src_a = SELW'($urandom);
    bus.src_b = SELW'($urandom);
    bus.dst   = SELW'($urandom);
    bus.imm   = DW'($urandom);
    bus.fn    = FNW'($urandom);
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    drive_cmd(OP_LDI, 3'd1, 3'd2, 3'd3, 16'hFFFF, 4'hF);
    cyc();
    cyc();
    n_cmp++; if (bus.RA !== 8'h00) begin n_bad++; $display("FAIL rst_RA: got %h required 00", bus.RA); end
    n_cmp++; if (bus.RB !== 8'h00) begin n_bad++; $display("FAIL rst_RB: got %h required 00", bus.RB); end
    n_cmp++; if (bus.SR !== 8'h00) begin n_bad++; $display("FAIL rst_SR: got %h required 00", bus.SR); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b required 0", bus.done); end
    n_cmp++; if (bus.S_bus !== 16'h0000) begin n_bad++; $display("FAIL rst_S: got %h required 0000", bus.S_bus); end
    n_cmp++; if (bus.alu_fn !== 4'h0) begin n_bad++; $display("FAIL rst_fn: got %h required 0", bus.alu_fn); end
    CLR = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_mov();
    gpr[2] = 16'h1234;
    drive_cmd(OP_MOV, 3'd2, 3'd0, 3'd5, 16'h0000, 4'h0);
    cyc();
    noise(1'b0);
    n_cmp++; if (bus.RA !== 8'b00000100) begin n_bad++; $display("FAIL mov_RA: got %b required 00000100", bus.RA); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mov_busy: got %b required 1", bus.busy); end
    cyc();
    n_cmp++; if (bus.SR !== 8'b00100000) begin n_bad++; $display("FAIL mov_SR: got %b required 00100000", bus.SR); end
    n_cmp++; if (bus.S_bus !== 16'h1234) begin n_bad++; $display("FAIL mov_S: got %h required 1234", bus.S_bus); end
    n_cmp++; if (bus.RA !== 8'h00) begin n_bad++; $display("FAIL mov_RA_w: got %h required 00", bus.RA); end
    cyc();
    n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL mov_done: got done=%b busy=%b required 1/0", bus.done, bus.busy); end
    n_cmp++; if (gpr[5] !== 16'h1234) begin n_bad++; $display("FAIL mov_R5: got %h required 1234", gpr[5]); end
  endtask

  task automatic test_alu();
    force_alu = 1'b1;
    forced_y  = 16'hBEEF;
    drive_cmd(OP_ALU, 3'd1, 3'd3, 3'd1, 16'h0000, 4'h2);
    cyc();
    noise(1'b0);
    n_cmp++; if (bus.RA !== 8'h02 || bus.RB !== 8'h08) begin n_bad++; $display("FAIL alu_sel: got RA=%h RB=%h required 02/08", bus.RA, bus.RB); end
    n_cmp++; if (bus.alu_fn !== 4'h2) begin n_bad++; $display("FAIL alu_fn: got %h required 2", bus.alu_fn); end
    cyc();
    n_cmp++; if (bus.SR !== 8'h02) begin n_bad++; $display("FAIL alu_SR: got %h required 02", bus.SR); end
    n_cmp++; if (bus.S_bus !== 16'hBEEF) begin n_bad++; $display("FAIL alu_S: got %h required BEEF", bus.S_bus); end
    n_cmp++; if (bus.alu_fn !== 4'h2) begin n_bad++; $display("FAIL alu_fn_hold: got %h required 2", bus.alu_fn); end
    cyc();
    force_alu = 1'b0;
  endtask

  task automatic test_ldi_clr();
    drive_cmd(OP_LDI, 3'd4, 3'd6, 3'd7, 16'hA5A5, 4'h0);
    cyc();
    noise(1'b0);
    n_cmp++; if (bus.RA !== 8'h00 || bus.RB !== 8'h00) begin n_bad++; $display("FAIL ldi_sel: got RA=%h RB=%h required 00/00", bus.RA, bus.RB); end
    cyc();
    n_cmp++; if (bus.SR !== 8'h80 || bus.S_bus !== 16'hA5A5) begin n_bad++; $display("FAIL ldi_wr: got SR=%h S=%h required 80/A5A5", bus.SR, bus.S_bus); end
    drive_cmd(OP_CLR, 3'd5, 3'd5, 3'd0, 16'hFFFF, 4'h0);
    cyc();
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ldi_done: got %b required 1", bus.done); end
    cyc();
    noise(1'b0);
    n_cmp++; if (bus.RA !== 8'h00 || bus.RB !== 8'h00) begin n_bad++; $display("FAIL clr_sel: got RA=%h RB=%h required 00/00", bus.RA, bus.RB); end
    cyc();
    n_cmp++; if (bus.SR !== 8'h01 || bus.S_bus !== 16'h0000) begin n_bad++; $display("FAIL clr_wr: got SR=%h S=%h required 01/0000", bus.SR, bus.S_bus); end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [SELW-1:0] acc_d;
    logic [DW-1:0]   acc_imm;
    acc_d   = '0;
    acc_imm = '0;
    for (int k = 0; k < 12; k++) begin
      drive_cmd(OP_LDI, SELW'($urandom), SELW'($urandom), SELW'($urandom), DW'($urandom), FNW'($urandom));
      if (k % 3 == 0) begin
        acc_d   = bus.dst;
        acc_imm = bus.imm;
      end
      cyc();
      case (k % 3)
        0: begin
          n_cmp++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b_read k=%0d: got busy=%b done=%b required 1/0", k, bus.busy, bus.done); end
        end
        1: begin
          n_cmp++; if (bus.SR !== (8'h01 << acc_d) || bus.S_bus !== acc_imm) begin n_bad++; $display("FAIL b2b_write k=%0d: got SR=%h S=%h required %h/%h", k, bus.SR, bus.S_bus, 8'h01 << acc_d, acc_imm); end
        end
        default: begin
          n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin n_bad++; $display("FAIL b2b_done k=%0d: got busy=%b done=%b required 0/1", k, bus.busy, bus.done); end
        end
      endcase
    end
    bus.start = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_write();
    drive_cmd(OP_LDI, 3'd0, 3'd0, 3'd3, 16'h1111, 4'h9);
    cyc();
    bus.start = 1'b0;
    cyc();
    n_cmp++; if (bus.SR !== 8'h08) begin n_bad++; $display("FAIL rmw_pre: got SR=%h required 08", bus.SR); end
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    n_cmp++; if (bus.SR !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rmw_ctl: got SR=%h busy=%b done=%b required 00/0/0", bus.SR, bus.busy, bus.done); end
    n_cmp++; if (bus.S_bus !== 16'h0000 || bus.alu_fn !== 4'h0) begin n_bad++; $display("FAIL rmw_data: got S=%h fn=%h required 0000/0", bus.S_bus, bus.alu_fn); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (bus.SR !== 8'h00 || bus.done !== 1'b0) begin n_bad++; $display("FAIL rmw_after %0d: got SR=%h done=%b required 00/0", i, bus.SR, bus.done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]      op;
    logic [SELW-1:0] a, b, d;
    logic [DW-1:0]   imm;
    logic [FNW-1:0]  fn;
    for (int i = 0; i < NREG; i++) begin
      gpr[i]   = DW'($urandom);
      model[i] = gpr[i];
    end
    for (int n = 0; n < 1000; n++) begin
      op  = 2'($urandom);
      a   = SELW'($urandom);
      b   = SELW'($urandom);
      d   = SELW'($urandom);
      imm = DW'($urandom);
      fn  = FNW'($urandom);
      case (op)
        2'b00:   model[d] = model[a];
        2'b01:   model[d] = alu_f(model[a], model[b], fn);
        2'b10:   model[d] = imm;
        default: model[d] = '0;
      endcase
      drive_cmd(op, a, b, d, imm, fn);
      cyc();
      noise(1'($urandom));
      cyc();
      noise(1'($urandom));
      cyc();
      bus.start = 1'b0;
      n_cmp++; if (gpr[d] !== model[d] || bus.done !== 1'b1) begin n_bad++; $display("FAIL rnd cmd %0d op=%0d R%0d: got %h done=%b required %h/1", n, op, d, gpr[d], bus.done, model[d]); end
      if ($urandom_range(0, 3) == 0) cyc();
    end
    for (int i = 0; i < NREG; i++) begin
      n_cmp++; if (gpr[i] !== model[i]) begin n_bad++; $display("FAIL rnd_final R%0d: got %h required %h", i, gpr[i], model[i]); end
    end
  endtask

  initial begin
    CLR       = 1'b1;
    force_alu = 1'b0;
    forced_y  = '0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.dst   = '0;
    bus.imm   = '0;
    bus.fn    = '0;
    for (int i = 0; i < NREG; i++) gpr[i] = '0;
    @(negedge CLK);
    test_reset();
    test_mov();
    test_alu();
    test_ldi_clr();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
